// File: rtl/mt_state_recover.sv
// Recovers MT19937 state words by inverting tempering on N consecutive generator outputs.
// Define MT_STATE_RECOVER_CHECK_EN to add a forward re-tempering comparator and a sticky mismatch output.
module mt_state_recover #(
  parameter int          N      = 624,
  parameter int          U      = 11,
  parameter logic [31:0] D      = 32'hFFFFFFFF,
  parameter int          S      = 7,
  parameter logic [31:0] B      = 32'h9D2C5680,
  parameter int          T      = 15,
  parameter logic [31:0] C      = 32'hEFC60000,
  parameter int          L      = 18,
  parameter int          ITER_L = (32 + L - 1) / L - 1,
  parameter int          ITER_T = (32 + T - 1) / T - 1,
  parameter int          ITER_S = (32 + S - 1) / S - 1,
  parameter int          ITER_U = (32 + U - 1) / U - 1,
  localparam int         CW     = $clog2(N + 1),
  localparam int         AW     = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          gen_ready,
  input  logic [31:0]   gen_r_num,
  output logic          gen_trig,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] count,
  input  logic [AW-1:0] rd_addr,
  output logic [31:0]   rd_data
`ifdef MT_STATE_RECOVER_CHECK_EN
  ,
  output logic          mismatch
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_CAPT,
    S_UNTEMP,
    S_WRITE,
    S_DONE
  } state_t;

  // A phase with no iterations still runs one harmless step so the sequencer stays uniform.
  localparam logic [5:0] LAST_L = 6'(((ITER_L < 1) ? 1 : ITER_L) - 1);
  localparam logic [5:0] LAST_T = 6'(((ITER_T < 1) ? 1 : ITER_T) - 1);
  localparam logic [5:0] LAST_S = 6'(((ITER_S < 1) ? 1 : ITER_S) - 1);
  localparam logic [5:0] LAST_U = 6'(((ITER_U < 1) ? 1 : ITER_U) - 1);
  localparam logic [CW-1:0] LAST_WORD = CW'(N - 1);

  state_t      state_reg, state_next;
  logic [31:0] x_reg, y_reg;
  logic [1:0]  phase_reg;
  logic [5:0]  iter_reg;
  logic [CW-1:0] count_reg;
  logic [31:0] step_x;
  logic        phase_last;
  logic        start_accept;
  logic        write_en;

  logic [31:0] mem [0:N-1];

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:   if (start) state_next = S_REQ;
      S_REQ:    if (gen_trig) state_next = S_CAPT;
      S_CAPT:   state_next = S_UNTEMP;
      S_UNTEMP: if (phase_reg == 2'd3 && phase_last) state_next = S_WRITE;
      S_WRITE:  state_next = (count_reg == LAST_WORD) ? S_DONE : S_REQ;
      S_DONE:   if (start) state_next = S_REQ;
      default:  state_next = S_IDLE;
    endcase
  end

  // Outputs; trig is masked by rst so no word is pulled from the generator during an abort.
  always_comb begin
    gen_trig     = (state_reg == S_REQ) && gen_ready && !rst;
    busy         = (state_reg == S_REQ) || (state_reg == S_CAPT) ||
                   (state_reg == S_UNTEMP) || (state_reg == S_WRITE);
    done         = (state_reg == S_DONE);
    start_accept = start && ((state_reg == S_IDLE) || (state_reg == S_DONE));
    write_en     = (state_reg == S_WRITE);
  end

  // One shift-xor inversion step; phases run L, T, S, U (reverse of forward tempering).
  always_comb begin
    step_x     = y_reg;
    phase_last = 1'b0;
    case (phase_reg)
      2'd0: begin
        step_x     = y_reg ^ (x_reg >> L);
        phase_last = (iter_reg == LAST_L);
      end
      2'd1: begin
        step_x     = y_reg ^ ((x_reg << T) & C);
        phase_last = (iter_reg == LAST_T);
      end
      2'd2: begin
        step_x     = y_reg ^ ((x_reg << S) & B);
        phase_last = (iter_reg == LAST_S);
      end
      default: begin
        step_x     = y_reg ^ ((x_reg >> U) & D);
        phase_last = (iter_reg == LAST_U);
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x_reg     <= '0;
      y_reg     <= '0;
      phase_reg <= '0;
      iter_reg  <= '0;
      count_reg <= '0;
    end else begin
      if (start_accept) begin
        count_reg <= '0;
      end
      if (state_reg == S_CAPT) begin
        x_reg     <= gen_r_num;
        y_reg     <= gen_r_num;
        phase_reg <= 2'd0;
        iter_reg  <= '0;
      end
      if (state_reg == S_UNTEMP) begin
        x_reg <= step_x;
        if (phase_last) begin
          y_reg     <= step_x;
          phase_reg <= phase_reg + 2'd1;
          iter_reg  <= '0;
        end else begin
          iter_reg <= iter_reg + 6'd1;
        end
      end
      if (write_en) begin
        count_reg <= count_reg + 1'b1;
      end
    end
  end

  assign count = count_reg;

  always_ff @(posedge clk) begin
    if (write_en) begin
      mem[count_reg[AW-1:0]] <= x_reg;
    end
  end

  // Registered read; a same-cycle write to rd_addr is seen on the following read.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data <= '0;
    end else begin
      rd_data <= mem[rd_addr];
    end
  end

`ifdef MT_STATE_RECOVER_CHECK_EN
  logic [31:0] cap_reg;
  logic [31:0] fwd_x;

  always_comb begin
    fwd_x = x_reg;
    fwd_x = fwd_x ^ ((fwd_x >> U) & D);
    fwd_x = fwd_x ^ ((fwd_x << S) & B);
    fwd_x = fwd_x ^ ((fwd_x << T) & C);
    fwd_x = fwd_x ^ (fwd_x >> L);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cap_reg  <= '0;
      mismatch <= 1'b0;
    end else begin
      if (state_reg == S_CAPT) begin
        cap_reg <= gen_r_num;
      end
      if (start_accept) begin
        mismatch <= 1'b0;
      end else if (write_en && (fwd_x != cap_reg)) begin
        mismatch <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mt_state_recover.sv
// Randomized self-checking bench for mt_state_recover with a behavioural generator and untemper model.
module tb_mt_state_recover;
  localparam int N  = 624;
  localparam int CW = $clog2(N + 1);
  localparam int AW = $clog2(N);
  localparam logic [31:0] MB = 32'h9D2C5680;
  localparam logic [31:0] MC = 32'hEFC60000;
  localparam logic [31:0] MD = 32'hFFFFFFFF;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          gen_ready = 1'b0;
  logic [31:0]   gen_r_num = 32'h0;
  logic          gen_trig;
  logic          busy;
  logic          done;
  logic [CW-1:0] count;
  logic [AW-1:0] rd_addr = '0;
  logic [31:0]   rd_data;
`ifdef MT_STATE_RECOVER_CHECK_EN
  logic          mismatch;
`endif

  int checks = 0;
  int failures = 0;

  mt_state_recover dut (
    .clk(clk), .rst(rst), .start(start), .gen_ready(gen_ready), .gen_r_num(gen_r_num),
    .gen_trig(gen_trig), .busy(busy), .done(done), .count(count),
    .rd_addr(rd_addr), .rd_data(rd_data)
`ifdef MT_STATE_RECOVER_CHECK_EN
    , .mismatch(mismatch)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural generator: mode 0 constant, 1 random (first two fixed), 2 real MT19937 seed 5489
  int          gen_mode = 0;
  logic [31:0] const_val = 32'h0;
  int          gen_idx = 0;
  bit          ready_rand = 0;
  bit          ready_low = 0;
  logic [31:0] mt_state [N];
  logic [31:0] sent [$];

  function automatic logic [31:0] temper(input logic [31:0] v);
    logic [31:0] y;
    y = v;
    y = y ^ ((y >> 11) & MD);
    y = y ^ ((y << 7) & MB);
    y = y ^ ((y << 15) & MC);
    y = y ^ (y >> 18);
    return y;
  endfunction

  // Bit-serial inverses: solve each output bit from already-recovered bits
  function automatic logic [31:0] inv_right(input logic [31:0] y, input int sh, input logic [31:0] m);
    logic [31:0] x;
    x = '0;
    for (int i = 31; i >= 0; i--) begin
      if (i + sh <= 31) x[i] = y[i] ^ (x[i+sh] & m[i]);
      else x[i] = y[i];
    end
    return x;
  endfunction

  function automatic logic [31:0] inv_left(input logic [31:0] y, input int sh, input logic [31:0] m);
    logic [31:0] x;
    x = '0;
    for (int i = 0; i < 32; i++) begin
      if (i >= sh) x[i] = y[i] ^ (x[i-sh] & m[i]);
      else x[i] = y[i];
    end
    return x;
  endfunction

  function automatic logic [31:0] untemper(input logic [31:0] v);
    return inv_right(inv_left(inv_left(inv_right(v, 18, MD), 15, MC), 7, MB), 11, MD);
  endfunction

  task automatic mt_init();
    logic [31:0] y;
    mt_state[0] = 32'd5489;
    for (int i = 1; i < N; i++)
      mt_state[i] = 32'd1812433253 * (mt_state[i-1] ^ (mt_state[i-1] >> 30)) + 32'(i);
    for (int i = 0; i < N; i++) begin
      y = (mt_state[i] & 32'h80000000) | (mt_state[(i+1)%N] & 32'h7FFFFFFF);
      mt_state[i] = mt_state[(i+397)%N] ^ (y >> 1) ^ (y[0] ? 32'h9908B0DF : 32'h0);
    end
  endtask

  always @(negedge clk) begin
    logic [31:0] v;
    gen_ready = !(ready_low || (ready_rand && ($urandom_range(0, 3) == 0)));
    #2;
    if (gen_trig) begin
      checks++;
      if (gen_ready !== 1'b1) begin
        failures++;
        $display("FAIL trig_without_ready: gen_trig=1 gen_ready=%b required ready=1", gen_ready);
      end
      case (gen_mode)
        0: v = const_val;
        1: v = (gen_idx == 0) ? 32'h0 : (gen_idx == 1) ? 32'hD091BB5C : $urandom;
        default: v = temper(mt_state[gen_idx % N]);
      endcase
      gen_idx++;
      gen_r_num = v;
      sent.push_back(v);
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    sent.delete();
    gen_idx = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int cyc);
    cyc = 0;
    while (!done && cyc < budget) begin
      tick();
      cyc++;
    end
    checks++;
    if (done !== 1'b1) begin
      failures++;
      $display("FAIL done_timeout: done=%b after %0d cycles required done=1", done, cyc);
    end
  endtask

  task automatic wait_count(input int target, input int budget);
    int cyc;
    int prev;
    cyc = 0;
    prev = int'(count);
    while (int'(count) != target && cyc < budget) begin
      tick();
      cyc++;
      checks++;
      if (int'(count) < prev || int'(count) > prev + 1) begin
        failures++;
        $display("FAIL count_monotonic: count=%0d previous=%0d required step 0 or 1", count, prev);
      end
      prev = int'(count);
    end
    checks++;
    if (int'(count) != target) begin
      failures++;
      $display("FAIL count_timeout: count=%0d required %0d", count, target);
    end
  endtask

  task automatic read_word(input int a, output logic [31:0] d);
    rd_addr = AW'(a);
    tick();
    d = rd_data;
  endtask

  task automatic check_sent_array(input int words);
    logic [31:0] d;
    logic [31:0] exp_w;
    checks++;
    if (sent.size() < words) begin
      failures++;
      $display("FAIL sent_size: trig pulses=%0d required at least %0d", sent.size(), words);
    end else begin
      for (int i = 0; i < words; i++) begin
        read_word(i, d);
        exp_w = untemper(sent[i]);
        checks++;
        if (d !== exp_w) begin
          failures++;
          $display("FAIL word_%0d: rd_data=%08h required %08h (tempered %08h)", i, d, exp_w, sent[i]);
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    checks++;
    if ({gen_trig, busy, done} !== 3'b000 || count !== '0 || rd_data !== 32'h0) begin
      failures++;
      $display("FAIL reset_state: trig=%b busy=%b done=%b count=%0d rd_data=%08h required all 0",
               gen_trig, busy, done, count, rd_data);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL idle_after_reset: busy=%b done=%b required 0 0", busy, done);
    end
  endtask

  task automatic test_constant();
    int cyc;
    logic [31:0] d;
    gen_mode = 0;
    const_val = 32'h00400091;
    ready_rand = 0;
    do_start();
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL busy_after_start: busy=%b required 1", busy);
    end
    wait_done(12 * N + 100, cyc);
    checks++;
    if (cyc != 12 * N) begin
      failures++;
      $display("FAIL done_latency: cycles=%0d required %0d", cyc, 12 * N);
    end
    checks++;
    if (int'(count) != N || busy !== 1'b0) begin
      failures++;
      $display("FAIL final_count: count=%0d busy=%b required %0d 0", count, busy, N);
    end
    repeat (5) tick();
    checks++;
    if (done !== 1'b1) begin
      failures++;
      $display("FAIL done_held: done=%b required 1", done);
    end
    checks++;
    if (sent.size() != N) begin
      failures++;
      $display("FAIL trig_count_const: pulses=%0d required %0d", sent.size(), N);
    end
    for (int i = 0; i < N; i++) begin
      read_word(i, d);
      checks++;
      if (d !== 32'h00000001) begin
        failures++;
        $display("FAIL const_word_%0d: rd_data=%08h required 00000001", i, d);
      end
    end
`ifdef MT_STATE_RECOVER_CHECK_EN
    checks++;
    if (mismatch !== 1'b0) begin
      failures++;
      $display("FAIL mismatch_clean: mismatch=%b required 0", mismatch);
    end
`endif
  endtask

  task automatic test_random();
    int cyc;
    logic [31:0] d;
    gen_mode = 1;
    ready_rand = 1;
    do_start();
    wait_done(40 * N, cyc);
    ready_rand = 0;
    checks++;
    if (int'(count) != N || sent.size() != N) begin
      failures++;
      $display("FAIL random_count: count=%0d pulses=%0d required %0d", count, sent.size(), N);
    end
    check_sent_array(N);
    read_word(0, d);
    checks++;
    if (d !== 32'h0) begin
      failures++;
      $display("FAIL zero_word: rd_data=%08h required 00000000", d);
    end
    read_word(1, d);
    checks++;
    if (temper(d) !== 32'hD091BB5C) begin
      failures++;
      $display("FAIL first_mt_word: temper(rd_data)=%08h required D091BB5C", temper(d));
    end
  endtask

  task automatic test_real_generator();
    int cyc;
    logic [31:0] d;
    gen_mode = 2;
    ready_rand = 0;
    do_start();
    wait_done(12 * N + 100, cyc);
    for (int i = 0; i < N; i++) begin
      read_word(i, d);
      checks++;
      if (d !== mt_state[i]) begin
        failures++;
        $display("FAIL mt_state_%0d: rd_data=%08h required %08h", i, d, mt_state[i]);
      end
    end
    rd_addr = AW'(0);
    tick();
    rd_addr = AW'(311);
    checks++;
    if (temper(rd_data) !== 32'hD091BB5C) begin
      failures++;
      $display("FAIL mt_addr0: temper(rd_data)=%08h required D091BB5C", temper(rd_data));
    end
    tick();
    rd_addr = AW'(623);
    checks++;
    if (rd_data !== mt_state[311]) begin
      failures++;
      $display("FAIL mt_addr311: rd_data=%08h required %08h", rd_data, mt_state[311]);
    end
    tick();
    checks++;
    if (rd_data !== mt_state[623]) begin
      failures++;
      $display("FAIL mt_addr623: rd_data=%08h required %08h", rd_data, mt_state[623]);
    end
  endtask

  task automatic test_stall_and_abort();
    logic [31:0] d;
    logic [31:0] exp_w;
    gen_mode = 1;
    ready_rand = 0;
    do_start();
    wait_count(50, 2000);
    ready_low = 1;
    for (int c = 0; c < 700; c++) begin
      start = (c == 10);
      tick();
      checks++;
      if (gen_trig !== 1'b0 || int'(count) != 50 || busy !== 1'b1) begin
        failures++;
        $display("FAIL stall_cycle_%0d: trig=%b count=%0d busy=%b required 0 50 1", c, gen_trig, count, busy);
      end
    end
    start = 1'b0;
    ready_low = 0;
    wait_count(100, 2000);
    rst = 1'b1;
    tick();
    checks++;
    if ({gen_trig, busy, done} !== 3'b000 || count !== '0) begin
      failures++;
      $display("FAIL abort_state: trig=%b busy=%b done=%b count=%0d required all 0", gen_trig, busy, done, count);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (sent.size() != 100) begin
      failures++;
      $display("FAIL stall_pulses: pulses=%0d required 100", sent.size());
    end
    check_sent_array(100);
    do_start();
    wait_count(3, 200);
    for (int i = 0; i < 3; i++) begin
      read_word(i, d);
      exp_w = untemper(sent[i]);
      checks++;
      if (d !== exp_w) begin
        failures++;
        $display("FAIL restart_word_%0d: rd_data=%08h required %08h", i, d, exp_w);
      end
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    mt_init();
    test_reset();
    test_constant();
    test_random();
    test_real_generator();
    test_stall_and_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
